itcm_loader: RTL and testbench
==============================

Name: itcm_loader

Overview:
- Boot-time writer for the ITCM write port, which the instruction fetch path leaves unused.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to ITCM through WADDR/WDATA/WEN.
- Holds the core in reset until a frame has loaded and its checksum has passed.

Parameters:
AW, 18, ITCM byte-address width; WADDR advances by 4 per word.
DW, 32, ITCM data width; only 32 is supported.
HOLD_AT_RESET, 1, reset value of core_hold (1 = core held until first successful load).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
load_start  input  1  one-cycle pulse that starts a frame; ignored unless state is IDLE, DONE or ERR.
s_valid  input  1  byte-stream valid.
s_data  input  8  byte-stream data.
s_ready  output  1  byte accepted when s_valid && s_ready at a rising clk edge.
itcm_WADDR  output  AW  ITCM write byte address.
itcm_WDATA  output  DW  ITCM write data.
itcm_WEN  output  1  ITCM write strobe, one cycle per word.
core_hold  output  1  high = keep core in reset (drives core rst_n = ~core_hold at top level).
busy  output  1  high in LEN, DATA and CSUM states.
done  output  1  level; high in DONE.
err  output  1  level; high in ERR.
words_loaded  output  AW-1  count of words written in the current frame.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; s_ready=0; itcm_WEN=0; itcm_WADDR=0; itcm_WDATA=0.
  - busy=0; done=0; err=0; words_loaded=0; core_hold=HOLD_AT_RESET.
- Reset mid-frame aborts the frame. Words already written stay in ITCM; the loader does not clear them.
- Frame format, little-endian, one byte per handshake:
  - 4 length bytes giving N, the word count.
  - 4*N data bytes.
  - 1 checksum byte C.
- Checksum rule: the 8-bit sum modulo 256 of all length, data and C bytes must equal 0x00.
- States:
  - IDLE/DONE/ERR: s_ready=0. On load_start, go to LEN, clear the byte counter, sum, words_loaded and WADDR, set core_hold=1, clear done and err.
  - LEN: s_ready=1. After the 4th accepted byte, latch N.
    - If N > 2^(AW-2), go to ERR.
    - Else if N==0, go to CSUM.
    - Else go to DATA.
  - DATA: s_ready=1. Bytes fill WDATA LSB first: byte k of the word goes to bits [8k+7:8k].
    - On the 4th byte's handshake edge, register WDATA with the complete word; itcm_WEN=1 in the following cycle, with WADDR valid in the same cycle.
    - WADDR increments by 4 and words_loaded increments by 1 in the cycle after WEN.
    - After the N-th word, go to CSUM.
  - CSUM: s_ready=1. On the accepted byte:
    - If (sum+byte) mod 256 == 0, go to DONE and set core_hold=0.
    - Otherwise go to ERR; core_hold stays 1.
- s_valid low stalls the frame indefinitely; there is no timeout.
- load_start while busy is ignored.
- load_start in DONE re-holds the core and reloads.
- Sustained throughput: one byte per cycle. A back-to-back stream produces one WEN every 4 cycles.
- WADDR never wraps within a frame, because of the N limit.

Test Plan:
- Reset then idle: rst pulse, no load_start -> core_hold=1, s_ready=0, itcm_WEN=0, done=0, err=0.
- Good 2-word frame, bytes 02 00 00 00 13 00 00 00 93 00 10 00 48 sent back-to-back -> WEN pulse with WADDR=0x00000/WDATA=0x00000013, then WEN with WADDR=0x00004/WDATA=0x00100093, 4 cycles apart -> done=1, core_hold=0, words_loaded=2.
- Same frame with checksum 0x47 -> both words written, err=1, core_hold=1, done=0.
- Stalled stream: same good frame with s_valid low for 3 cycles between every byte -> identical writes and final state; WEN is never asserted during a stall.
- Bad length: bytes 01 00 01 00 (N=0x00010001 > 65536) -> err=1 after the 4th byte, no WEN ever asserted, s_ready=0.
- Zero length and abort:
  - Frame 00 00 00 00 00 -> done=1 with no WEN.
  - Separately, assert rst after the 6th byte of the good frame -> outputs return to reset values immediately; a following load_start and the full good frame completes normally.

Source files
------------

// File: rtl/itcm_loader.sv
// itcm_loader: turns a framed little-endian byte stream into 32-bit ITCM writes and
// holds the core in reset until a frame with a good checksum has been loaded.
// Latency: itcm_WEN one cycle after a word's 4th byte; done/err one cycle after the checksum byte.
// Backpressure: s_ready high only while a frame is in progress; s_valid low stalls forever, no timeout.
module itcm_loader #(
  parameter int AW            = 18,   // ITCM byte-address width
  parameter int DW            = 32,   // ITCM data width, only 32 is meaningful
  parameter bit HOLD_AT_RESET = 1'b1  // core_hold value coming out of reset
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic [AW-1:0] itcm_WADDR,
  output logic [DW-1:0] itcm_WDATA,
  output logic          itcm_WEN,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-2:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Largest word count that still fits the ITCM without WADDR wrapping.
  localparam logic [31:0] N_MAX = 32'd1 << (AW - 2);

  state_t        state_q;
  logic          s_ready_q;
  logic          wen_q;
  logic          core_hold_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic [AW-2:0] words_q;
  logic [AW-2:0] rem_q;   // words still to receive in this frame
  logic [23:0]   asm_q;   // first three bytes of the current 4-byte group, byte 0 lowest
  logic [1:0]    bcnt_q;  // byte position within the current 4-byte group
  logic [7:0]    sum_q;   // running mod-256 sum of every accepted byte

  logic          accept;
  logic [7:0]    sum_d;
  logic [31:0]   word_d;

  // Handshake qualifier, next running sum and the completed little-endian group.
  always_comb begin
    accept = s_valid && s_ready_q;
    sum_d  = sum_q + s_data;
    word_d = {s_data, asm_q};
  end

  // Frame FSM with all outputs registered; write bookkeeping runs alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      s_ready_q   <= 1'b0;
      wen_q       <= 1'b0;
      core_hold_q <= HOLD_AT_RESET;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      words_q     <= '0;
      rem_q       <= '0;
      asm_q       <= '0;
      bcnt_q      <= '0;
      sum_q       <= '0;
    end else begin
      // The strobe lasts one cycle; address and count advance once it has been seen.
      wen_q <= 1'b0;
      if (wen_q) begin
        waddr_q <= waddr_q + AW'(4);
        words_q <= words_q + (AW-1)'(1);
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_start) begin
            state_q     <= S_LEN;
            s_ready_q   <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_hold_q <= 1'b1;
            bcnt_q      <= '0;
            sum_q       <= '0;
            words_q     <= '0;
            waddr_q     <= '0;
          end
        end

        S_LEN: begin
          if (accept) begin
            sum_q  <= sum_d;
            bcnt_q <= bcnt_q + 2'd1;
            asm_q  <= {s_data, asm_q[23:8]};
            if (bcnt_q == 2'd3) begin
              if (word_d > N_MAX) begin
                // Frame would overrun the ITCM: refuse it before any write happens.
                state_q   <= S_ERR;
                s_ready_q <= 1'b0;
                busy_q    <= 1'b0;
                err_q     <= 1'b1;
              end else if (word_d == 32'd0) begin
                state_q <= S_CSUM;
              end else begin
                rem_q   <= word_d[AW-2:0];
                state_q <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            sum_q  <= sum_d;
            bcnt_q <= bcnt_q + 2'd1;
            asm_q  <= {s_data, asm_q[23:8]};
            if (bcnt_q == 2'd3) begin
              wdata_q <= word_d;
              wen_q   <= 1'b1;
              rem_q   <= rem_q - (AW-1)'(1);
              if (rem_q == (AW-1)'(1)) begin
                state_q <= S_CSUM;
              end
            end
          end
        end

        S_CSUM: begin
          if (accept) begin
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            if (sum_d == 8'd0) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              core_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign itcm_WADDR   = waddr_q;
  assign itcm_WDATA   = wdata_q;
  assign itcm_WEN     = wen_q;
  assign core_hold    = core_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_itcm_loader.sv
`timescale 1ns/1ps
// Bench for itcm_loader: frame-level reference model, per-cycle compare, directed and random frames.
module tb_itcm_loader;
  localparam int     AW   = 18;
  localparam longint NLIM = longint'(1) << (AW - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic [AW-1:0] itcm_WADDR;
  logic [31:0]   itcm_WDATA;
  logic          itcm_WEN;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-2:0] words_loaded;

  itcm_loader #(.AW(AW), .DW(32), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .itcm_WADDR(itcm_WADDR), .itcm_WDATA(itcm_WDATA), .itcm_WEN(itcm_WEN),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit run     = 1'b0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t wlog[$];

  logic [7:0] fq[$];
  logic [7:0] good[13] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00, 8'h48};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model: frame position decides everything ----------------
  bit          m_active = 0, m_done = 0, m_err = 0, m_hold = 1, m_wen = 0;
  int          m_words = 0, m_wk = 0, m_p = 0;
  longint      m_n = 0;
  logic [7:0]  m_sum;
  logic [31:0] m_wdata = 0;
  logic [7:0]  m_bytes[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_hold = 1; m_wen = 0; m_words = 0;
      m_bytes.delete();
    end else begin
      if (m_wen) m_words++;
      m_wen = 0;
      if (!m_active) begin
        if (load_start) begin
          m_active = 1; m_done = 0; m_err = 0; m_hold = 1; m_words = 0;
          m_bytes.delete();
        end
      end else if (s_valid) begin
        m_bytes.push_back(s_data);
        m_p = m_bytes.size();
        if (m_p == 4) begin
          m_n = longint'({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
          if (m_n > NLIM) begin
            m_active = 0; m_err = 1;
          end
        end else if (m_p > 4 && m_p <= 4 + 4 * m_n) begin
          if ((m_p - 4) % 4 == 0) begin
            m_wen   = 1;
            m_wk    = (m_p - 4) / 4 - 1;
            m_wdata = {m_bytes[m_p-1], m_bytes[m_p-2], m_bytes[m_p-3], m_bytes[m_p-4]};
          end
        end else if (m_p > 4) begin
          m_sum = 8'h00;
          foreach (m_bytes[i]) m_sum += m_bytes[i];
          m_active = 0;
          if (m_sum == 8'h00) begin
            m_done = 1; m_hold = 0;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- per-cycle compare, away from the active edge ----------------
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (run) begin
      chk("s_ready",      64'(s_ready),      64'(m_active));
      chk("busy",         64'(busy),         64'(m_active));
      chk("done",         64'(done),         64'(m_done));
      chk("err",          64'(err),          64'(m_err));
      chk("core_hold",    64'(core_hold),    64'(m_hold));
      chk("wen",          64'(itcm_WEN),     64'(m_wen));
      chk("words_loaded", 64'(words_loaded), 64'(m_words));
      if (m_wen) begin
        chk("waddr", 64'(itcm_WADDR), 64'(4 * m_wk));
        chk("wdata", 64'(itcm_WDATA), 64'(m_wdata));
      end
      if (rst) begin
        chk("rst_waddr", 64'(itcm_WADDR), 64'd0);
        chk("rst_wdata", 64'(itcm_WDATA), 64'd0);
      end
      if (itcm_WEN === 1'b1) begin
        e.cyc = cyc; e.addr = itcm_WADDR; e.data = itcm_WDATA;
        wlog.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bit got;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1; s_data = b; t = 0; got = 1'b0;
    while (!got && t < 64) begin
      @(negedge clk);
      if (s_ready) got = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    if (!got) chk("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input int gmin, input int gmax, input bit poke);
    foreach (fq[i]) begin
      load_start = poke && ($urandom_range(0, 7) == 0);
      send_byte(fq[i], int'($urandom_range(gmin, gmax)));
      load_start = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic load_good();
    fq.delete();
    foreach (good[i]) fq.push_back(good[i]);
  endtask

  task automatic chk_good_writes(input string tag, input int spacing);
    chk({tag, "_nwr"}, 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk({tag, "_addr0"}, 64'(wlog[0].addr), 64'h0);
      chk({tag, "_data0"}, 64'(wlog[0].data), 64'h0000_0013);
      chk({tag, "_addr1"}, 64'(wlog[1].addr), 64'h4);
      chk({tag, "_data1"}, 64'(wlog[1].data), 64'h0010_0093);
      chk({tag, "_spacing"}, 64'(wlog[1].cyc - wlog[0].cyc), 64'(spacing));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1; run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    // Reset then idle
    chk("idle_hold",  64'(core_hold), 64'd1);
    chk("idle_ready", 64'(s_ready),   64'd0);
    chk("idle_wen",   64'(itcm_WEN),  64'd0);
    chk("idle_done",  64'(done),      64'd0);
    chk("idle_err",   64'(err),       64'd0);

    // Good 2-word frame, back-to-back
    wlog.delete(); load_good(); pulse_start(); send_frame(0, 0, 0); idle(3);
    chk_good_writes("good", 4);
    chk("good_done",  64'(done),         64'd1);
    chk("good_hold",  64'(core_hold),    64'd0);
    chk("good_words", 64'(words_loaded), 64'd2);

    // Same frame, wrong checksum
    wlog.delete(); load_good(); fq[12] = 8'h47; pulse_start(); send_frame(0, 0, 0); idle(3);
    chk_good_writes("badsum", 4);
    chk("badsum_err",  64'(err),       64'd1);
    chk("badsum_hold", 64'(core_hold), 64'd1);
    chk("badsum_done", 64'(done),      64'd0);

    // Stalled stream: 3 idle cycles before every byte
    wlog.delete(); load_good(); pulse_start(); send_frame(3, 3, 0); idle(3);
    chk_good_writes("stall", 16);
    chk("stall_done",  64'(done),         64'd1);
    chk("stall_hold",  64'(core_hold),    64'd0);
    chk("stall_words", 64'(words_loaded), 64'd2);

    // Oversized length
    wlog.delete(); fq = '{8'h01, 8'h00, 8'h01, 8'h00}; pulse_start(); send_frame(0, 0, 0); idle(3);
    chk("badlen_err",   64'(err),         64'd1);
    chk("badlen_nwr",   64'(wlog.size()), 64'd0);
    chk("badlen_ready", 64'(s_ready),     64'd0);

    // Zero-length frame
    wlog.delete(); fq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; pulse_start(); send_frame(0, 0, 0); idle(3);
    chk("zero_done", 64'(done),         64'd1);
    chk("zero_nwr",  64'(wlog.size()),  64'd0);
    chk("zero_hold", 64'(core_hold),    64'd0);

    // Abort after the 6th byte, then a full reload
    load_good();
    while (fq.size() > 6) void'(fq.pop_back());
    pulse_start(); send_frame(0, 0, 0);
    rst = 1'b1;
    #1;
    chk("abort_hold",  64'(core_hold),    64'd1);
    chk("abort_ready", 64'(s_ready),      64'd0);
    chk("abort_busy",  64'(busy),         64'd0);
    chk("abort_words", 64'(words_loaded), 64'd0);
    chk("abort_waddr", 64'(itcm_WADDR),   64'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    wlog.delete(); load_good(); pulse_start(); send_frame(0, 0, 0); idle(3);
    chk_good_writes("reload", 4);
    chk("reload_done",  64'(done),         64'd1);
    chk("reload_words", 64'(words_loaded), 64'd2);

    // Random frames: random lengths, stalls, checksums, ignored load_start while busy
    for (int f = 0; f < 30; f++) begin
      int          n;
      logic [7:0]  s;
      logic [7:0]  c;
      logic [31:0] lw;
      fq.delete();
      if ($urandom_range(0, 7) == 0) begin
        lw = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0001_0001 + 32'($urandom_range(0, 1000));
        for (int k = 0; k < 4; k++) fq.push_back(lw[8*k +: 8]);
      end else begin
        n  = int'($urandom_range(0, 5));
        lw = 32'(n);
        for (int k = 0; k < 4; k++) fq.push_back(lw[8*k +: 8]);
        for (int k = 0; k < 4 * n; k++) fq.push_back(8'($urandom_range(0, 255)));
        s = 8'h00;
        foreach (fq[k]) s += fq[k];
        c = 8'h00 - s;
        if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
        fq.push_back(c);
      end
      pulse_start();
      send_frame(0, int'($urandom_range(0, 2)), 1'b1);
      idle(int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
